// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: FSM states,
// access sizes, load/store codes and the latched transaction context.
package mem_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  typedef struct packed {
    owner_e              owner;
    logic [CNT_W-1:0]    len;
    logic [DATA_W-1:0]   wdata;
  } txn_ctx_t;

  // Byte count of an access; the reserved size code behaves as a word.
  function automatic logic [CNT_W-1:0] size_len(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_len = 3'd1;
      SZ_HALF: size_len = 3'd2;
      default: size_len = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and data accesses onto a byte-wide RAM,
// moving one byte per cycle; data-memory requests win ties.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_rw,
  input  logic [1:0]        dm_size,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [31:0]       dm_wdata,
  output logic [31:0]       dm_rdata,
  output logic              dm_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic              busy
);

  state_e             state, state_d;
  logic [CNT_W-1:0]   c, c_d;
  logic [ADDR_W-1:0]  base, base_d;
  txn_ctx_t           ctx, ctx_d;
  logic [DATA_W-1:0]  rbuf, rbuf_d;
  logic [DATA_W-1:0]  if_data_d, dm_rdata_d;
  logic               if_done_d, dm_done_d, ram_wr_d, busy_d;
  logic [ADDR_W-1:0]  ram_a_d;
  logic [7:0]         ram_dout_d;
  logic [4:0]         rd_lsb, wr_lsb;
  logic               flush_hit;

  assign flush_hit = if_flush && (state == ST_READ) && (ctx.owner == OWN_IF);

  // Next state plus the RAM/handshake outputs for the cycle that follows.
  always_comb begin
    state_d    = state;
    c_d        = c;
    base_d     = base;
    ctx_d      = ctx;
    rbuf_d     = rbuf;
    if_data_d  = if_data;
    dm_rdata_d = dm_rdata;
    rd_lsb     = {2'(c - 3'd1), 3'b000};

    unique case (state)
      ST_IDLE: begin
        if (dm_req) begin
          ctx_d   = '{owner: OWN_DM, len: size_len(dm_size), wdata: dm_wdata};
          base_d  = dm_addr;
          c_d     = '0;
          rbuf_d  = '0;
          state_d = (dm_rw == RW_STORE) ? ST_WRITE : ST_READ;
        end else if (if_req) begin
          ctx_d   = '{owner: OWN_IF, len: 3'd4, wdata: '0};
          base_d  = if_addr;
          c_d     = '0;
          rbuf_d  = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (flush_hit) begin
          state_d = ST_IDLE;
          c_d     = '0;
        end else begin
          // RAM data lags the address by a cycle, so count c carries byte c-1.
          if (c != '0) rbuf_d[rd_lsb +: 8] = ram_din;
          if (c == ctx.len) begin
            state_d = ST_DONE;
            c_d     = '0;
            if (ctx.owner == OWN_IF) if_data_d = rbuf_d;
            else                     dm_rdata_d = rbuf_d;
          end else begin
            c_d = c + 3'd1;
          end
        end
      end
      ST_WRITE: begin
        if (c == ctx.len - 3'd1) begin
          state_d = ST_DONE;
          c_d     = '0;
        end else begin
          c_d = c + 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    wr_lsb     = {2'(c_d), 3'b000};
    busy_d     = (state_d != ST_IDLE);
    if_done_d  = (state_d == ST_DONE) && (ctx_d.owner == OWN_IF);
    dm_done_d  = (state_d == ST_DONE) && (ctx_d.owner == OWN_DM);
    ram_wr_d   = (state_d == ST_WRITE);
    ram_a_d    = (ram_wr_d || ((state_d == ST_READ) && (c_d < ctx_d.len)))
                 ? base_d + ADDR_W'(c_d) : '0;
    ram_dout_d = ram_wr_d ? ctx_d.wdata[wr_lsb +: 8] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      c        <= '0;
      base     <= '0;
      ctx      <= '0;
      rbuf     <= '0;
      if_data  <= '0;
      dm_rdata <= '0;
      if_done  <= 1'b0;
      dm_done  <= 1'b0;
      ram_wr   <= 1'b0;
      ram_a    <= '0;
      ram_dout <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_d;
      c        <= c_d;
      base     <= base_d;
      ctx      <= ctx_d;
      rbuf     <= rbuf_d;
      if_data  <= if_data_d;
      dm_rdata <= dm_rdata_d;
      if_done  <= if_done_d;
      dm_done  <= dm_done_d;
      ram_wr   <= ram_wr_d;
      ram_a    <= ram_a_d;
      ram_dout <= ram_dout_d;
      busy     <= busy_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: vector table of data accesses plus
// hand-written fetch, arbitration, flush, wrap and reset sequences.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, if_flush = 1'b0, dm_req = 1'b0, dm_rw = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [1:0]  dm_size = '0;
  logic [31:0] if_data, dm_rdata, ram_a;
  logic        if_done, dm_done, ram_wr, busy;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = 8'h00;

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_data(if_data), .if_done(if_done),
    .dm_req(dm_req), .dm_rw(dm_rw), .dm_size(dm_size), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_done(dm_done),
    .ram_din(ram_din), .ram_dout(ram_dout), .ram_a(ram_a), .ram_wr(ram_wr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
    int          cyc;
  } wr_t;

  logic [7:0]  mem [4096] = '{default: 8'h00};
  wr_t         wlog [$];
  int          cyc = 0;
  int          if_done_cnt = 0, dm_done_cnt = 0, wr_cnt = 0;
  int          total = 0, bad = 0;
  logic [31:0] trace [16];

  // Byte RAM with one-cycle read latency, plus a log of every write.
  always @(posedge clk) begin
    if (ram_wr) begin
      mem[ram_a[11:0]] <= ram_dout;
      wlog.push_back('{ram_a, ram_dout, cyc});
    end
    ram_din <= mem[ram_a[11:0]];
    cyc     <= cyc + 1;
  end

  always @(negedge clk) begin
    if (if_done) if_done_cnt++;
    if (dm_done) dm_done_cnt++;
    if (ram_wr)  wr_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_dm(input logic rw, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rd, output int lat);
    @(negedge clk);
    dm_req = 1'b1; dm_rw = rw; dm_size = size; dm_addr = addr; dm_wdata = wdata;
    @(posedge clk); #1;
    trace[0] = ram_a;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk); #1;
      lat++;
      trace[lat] = ram_a;
      if (dm_done) break;
    end
    rd = dm_rdata;
    dm_req = 1'b0;
    @(posedge clk);
  endtask

  task automatic run_if(input logic [31:0] addr, output logic [31:0] rd, output int lat);
    @(negedge clk);
    if_req = 1'b1; if_addr = addr;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (if_done) break;
    end
    rd = if_data;
    if_req = 1'b0;
    @(posedge clk);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  initial begin
    vec_t        vt [10];
    logic [31:0] rd;
    int          lat, w0, n0, n1, n2;
    logic [7:0]  eb [4];

    vt[0] = '{RW_STORE, SZ_WORD, 32'h100, 32'h00A00513, 32'h0,        4};
    vt[1] = '{RW_LOAD,  SZ_BYTE, 32'h22,  32'h0,        32'h000000AD, 2};
    vt[2] = '{RW_LOAD,  SZ_HALF, 32'h22,  32'h0,        32'h0000DEAD, 3};
    vt[3] = '{RW_LOAD,  SZ_WORD, 32'h20,  32'h0,        32'hDEADBEEF, 5};
    vt[4] = '{RW_LOAD,  SZ_BYTE, 32'h103, 32'h0,        32'h00000000, 2};
    vt[5] = '{RW_STORE, SZ_HALF, 32'h40,  32'h1234ABCD, 32'h0,        2};
    vt[6] = '{RW_LOAD,  SZ_WORD, 32'h40,  32'h0,        32'h0000ABCD, 5};
    vt[7] = '{RW_STORE, SZ_BYTE, 32'h43,  32'hFFFFFF77, 32'h0,        1};
    vt[8] = '{RW_LOAD,  2'b11,   32'h40,  32'h0,        32'h7700ABCD, 5};
    vt[9] = '{RW_LOAD,  SZ_HALF, 32'h101, 32'h0,        32'h0000A005, 3};

    // Reset state
    #3 rst = 1'b0;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst ram_wr", 32'(ram_wr), 32'd0);
    chk("rst ram_a", ram_a, 32'h0);
    chk("rst dones", {30'd0, if_done, dm_done}, 32'd0);
    chk("rst if_data", if_data, 32'h0);
    chk("rst dm_rdata", dm_rdata, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    // Store word: four consecutive byte writes, little-endian
    eb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    w0 = wlog.size();
    run_dm(RW_STORE, SZ_WORD, 32'h20, 32'hDEADBEEF, rd, lat);
    chk("st word lat", 32'(lat), 32'd4);
    chk("st word nwr", 32'(wlog.size() - w0), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st word addr%0d", i), wlog[w0+i].a, 32'h20 + 32'(i));
      chk($sformatf("st word data%0d", i), 32'(wlog[w0+i].d), 32'(eb[i]));
      if (i > 0) chk($sformatf("st word cyc%0d", i), 32'(wlog[w0+i].cyc - wlog[w0].cyc), 32'(i));
    end
    #1 chk("done width", 32'(dm_done), 32'd0);

    // Vector table
    for (int i = 0; i < 10; i++) begin
      run_dm(vt[i].rw, vt[i].size, vt[i].addr, vt[i].wdata, rd, lat);
      chk($sformatf("vec%0d lat", i), 32'(lat), 32'(vt[i].exp_lat));
      if (vt[i].rw == RW_LOAD) chk($sformatf("vec%0d rdata", i), rd, vt[i].exp_rd);
    end

    // Instruction fetch
    run_if(32'h100, rd, lat);
    chk("fetch lat", 32'(lat), 32'd5);
    chk("fetch data", rd, 32'h00A00513);
    chk("dm_rdata hold", dm_rdata, 32'h0000A005);

    // Simultaneous requests: data side first, fetch after DONE
    n0 = if_done_cnt;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h100;
    dm_req = 1'b1; dm_rw = RW_LOAD; dm_size = SZ_HALF; dm_addr = 32'h22;
    @(posedge clk); #1;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk); #1; lat++;
      if (dm_done) break;
    end
    dm_req = 1'b0;
    chk("arb dm lat", 32'(lat), 32'd3);
    chk("arb dm data", dm_rdata, 32'h0000DEAD);
    chk("arb no if_done", 32'(if_done_cnt - n0), 32'd0);
    lat = 0;
    while (lat < 14) begin
      @(posedge clk); #1; lat++;
      if (if_done) break;
    end
    if_req = 1'b0;
    chk("arb if lat", 32'(lat), 32'd7);
    chk("arb if data", if_data, 32'h00A00513);
    @(posedge clk);

    // Flush at c=2 with a data request waiting
    n0 = if_done_cnt; n1 = wr_cnt;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h20;
    @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    if_flush = 1'b1; if_req = 1'b0;
    dm_req = 1'b1; dm_rw = RW_LOAD; dm_size = SZ_BYTE; dm_addr = 32'h22;
    @(posedge clk); #1;
    if_flush = 1'b0;
    chk("flush idle", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("flush dm accept", 32'(busy), 32'd1);
    lat = 0;
    while (lat < 12) begin
      @(posedge clk); #1; lat++;
      if (dm_done) break;
    end
    dm_req = 1'b0;
    chk("flush dm lat", 32'(lat), 32'd2);
    chk("flush dm data", dm_rdata, 32'h000000AD);
    @(posedge clk); #1;
    chk("flush no if_done", 32'(if_done_cnt - n0), 32'd0);
    chk("flush no ram_wr", 32'(wr_cnt - n1), 32'd0);
    chk("flush if_data hold", if_data, 32'h00A00513);

    // Address wrap at the top of the space
    w0 = wlog.size();
    run_dm(RW_STORE, SZ_WORD, 32'hFFFFFFFE, 32'h44332211, rd, lat);
    chk("wrap st addr2", wlog[w0+2].a, 32'h0);
    chk("wrap st addr3", wlog[w0+3].a, 32'h1);
    run_dm(RW_LOAD, SZ_WORD, 32'hFFFFFFFE, 32'h0, rd, lat);
    chk("wrap a0", trace[0], 32'hFFFFFFFE);
    chk("wrap a1", trace[1], 32'hFFFFFFFF);
    chk("wrap a2", trace[2], 32'h0);
    chk("wrap a3", trace[3], 32'h1);
    chk("wrap data", rd, 32'h44332211);

    // Reset during a store at c=1
    n2 = dm_done_cnt;
    @(negedge clk);
    dm_req = 1'b1; dm_rw = RW_STORE; dm_size = SZ_WORD; dm_addr = 32'h60; dm_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    chk("rw c0 addr", ram_a, 32'h60);
    @(posedge clk); #1;
    chk("rw c1 wr", 32'(ram_wr), 32'd1);
    #2 rst = 1'b0; dm_req = 1'b0;
    #1;
    chk("rw rst wr", 32'(ram_wr), 32'd0);
    chk("rw rst addr", ram_a, 32'h0);
    chk("rw rst busy", 32'(busy), 32'd0);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rw post busy", 32'(busy), 32'd0);
    chk("rw no done", 32'(dm_done_cnt - n2), 32'd0);
    chk("rw mem60", 32'(mem[12'h060]), 32'h0D);
    chk("rw mem61", 32'(mem[12'h061]), 32'h00);
    chk("rw if_data cleared", if_data, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
